alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Control FSM that sequences the integer execute datapath (ALU, shifter, HI/LO multiplier) and drives the 6-bit result-mux select (the funct code).
- Accepts one R-type funct per start pulse and times the operation. AND/OR/ADD/SUB/SLT/SLL/MFHI/MFLO take one cycle; MULTU takes 32 shift-add iterations.
- Issues datapath strobes and signals done to the decode/issue stage.

Parameters:
- MULT_CYCLES, 32, number of shift-add iterations for MULTU.
- CNT_W, 5, width of the iteration counter; must satisfy 2^CNT_W >= MULT_CYCLES.
- IDLE_SEL, 6'b111111, mux select driven when no result is valid. It is not a decoded funct, so the result mux outputs 0.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request strobe, sampled only in IDLE.
- funct  in  6  R-type funct code, sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when the latched funct is unsupported.
- mux_sel  out  6  result-mux select.
- alu_ctrl  out  3  ALU operation.
- rf_we  out  1  register-file write enable for the result.
- mult_load  out  1  multiplier loads operands and clears its HI/LO accumulator.
- mult_step  out  1  multiplier performs one shift-add iteration.
- hilo_we  out  1  commit multiplier product to HI/LO.
- iter_cnt  out  CNT_W  current MULTU iteration index.

Behaviour:
- Reset:
  - state=IDLE, op_reg=0, iter_cnt=0.
  - busy=done=err=rf_we=mult_load=mult_step=hilo_we=0, alu_ctrl=000, mux_sel=IDLE_SEL.
  - Reset mid-operation aborts at the next edge. No hilo_we and no done are produced for the aborted op.
- Outputs are Moore functions of state and op_reg; no combinational path from start or funct to any output.
- Supported funct codes:
  - AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010 (ALU class).
  - SLL 000000 (shift class).
  - MFHI 010000, MFLO 010010 (HI/LO read class).
  - MULTU 011001 (multi-cycle).
- alu_ctrl mapping: AND 000, OR 001, ADD 010, SUB 110, SLT 111; all other ops 000.
- States and transitions:
  - IDLE: if start, latch funct into op_reg. Next state is EXEC for single-cycle classes, MLOAD for MULTU, ERR otherwise. A start when not in IDLE is ignored, with no queueing.
  - EXEC (1 cycle): mux_sel=op_reg, alu_ctrl per mapping, rf_we=1. Next state DONE.
  - MLOAD (1 cycle): mult_load=1, mux_sel=IDLE_SEL, iter_cnt reset to 0. Next state MULT.
  - MULT: mult_step=1, iter_cnt increments each cycle. When iter_cnt==MULT_CYCLES-1, go to MWB; iter_cnt wraps to 0 there and never exceeds MULT_CYCLES-1.
  - MWB (1 cycle): hilo_we=1, rf_we=0. Next state DONE. MULTU never writes the register file.
  - ERR (1 cycle): no strobes. Next state DONE with err latched.
  - DONE (1 cycle): done=1, err=1 only if arrived via ERR, mux_sel=IDLE_SEL. Next state IDLE.
- Latency, from the edge sampling start to done high:
  - 2 cycles for single-cycle ops and for illegal codes.
  - MULT_CYCLES+3 cycles for MULTU (35 at default).
- Back-to-back: start is first accepted the cycle after DONE, so issue interval is 3 cycles for single-cycle ops and MULT_CYCLES+4 cycles for MULTU.
- MFHI/MFLO issued while busy are not accepted, so they always read a fully committed HI/LO.

Decomposition:
- Shared package alu_pkg holds:
  - funct localparams (AND/OR/ADD/SUB/SLT/SLL/MULTU/MFHI/MFLO);
  - ALU ctrl codes;
  - IDLE_SEL;
  - the state encoding (3-bit: IDLE, EXEC, MLOAD, MULT, MWB, ERR, DONE).
- One natural sub-module: funct_decode. It is combinational and maps funct to {op_class, alu_ctrl, legal}. It is reused by the hazard and forwarding logic.

Test Plan:
- Reset: hold reset 3 cycles mid-MULTU (iter_cnt=10) -> next cycle busy=0, iter_cnt=0, mux_sel=111111, no hilo_we or done ever pulses.
- ADD: start with funct=100000 -> cycle 1 mux_sel=100000, alu_ctrl=010, rf_we=1; cycle 2 done=1, err=0; cycle 3 busy=0.
- MULTU: start with funct=011001 -> mult_load in cycle 1; mult_step high for exactly 32 cycles with iter_cnt 0..31; hilo_we in cycle 34; done in cycle 35; rf_we never high.
- Illegal code: start with funct=000011 -> no strobes, done=1 and err=1 in cycle 2.
- Busy rejection: start MULTU, then pulse start with funct=010000 at cycles 5 and 34 -> both ignored, only one done; a following MFHI accepted after DONE drives mux_sel=010000 for one cycle.
- SLL then SLT back-to-back: mux_sel=000000 in EXEC, SLT accepted exactly 3 cycles after the first start, alu_ctrl=111, two done pulses.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the integer execute sequencer: funct codes, ALU controls,
// the idle mux select, FSM state encoding and the decoded operation classes.
package alu_pkg;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Not a decoded funct, so the result mux outputs zero.
  localparam logic [5:0] IDLE_SEL = 6'b111111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_MLOAD = 3'd2,
    S_MULT  = 3'd3,
    S_MWB   = 3'd4,
    S_ERR   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_SHIFT = 3'd1,
    CLS_HILO  = 3'd2,
    CLS_MULT  = 3'd3,
    CLS_NONE  = 3'd4
  } op_class_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Issue-side request and datapath control bundle of the execute sequencer.
// Handshake: start is a one-cycle strobe taken only while busy is low; each
// accepted start produces exactly one done pulse, and starts seen while busy are dropped.
interface alu_op_sequencer_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic [5:0]       funct;
  logic             busy;
  logic             done;
  logic             err;
  logic [5:0]       mux_sel;
  logic [2:0]       alu_ctrl;
  logic             rf_we;
  logic             mult_load;
  logic             mult_step;
  logic             hilo_we;
  logic [CNT_W-1:0] iter_cnt;
  alu_pkg::state_t  state;

  modport master (
    output start, funct,
    input  busy, done, err, mux_sel, alu_ctrl, rf_we,
           mult_load, mult_step, hilo_we, iter_cnt, state
  );

  modport slave (
    input  start, funct,
    output busy, done, err, mux_sel, alu_ctrl, rf_we,
           mult_load, mult_step, hilo_we, iter_cnt, state
  );
endinterface

// File: rtl/funct_decode.sv
// Combinational R-type funct decoder: operation class, ALU control and legality.
// Shared with the hazard and forwarding logic.
module funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output op_class_t  op_class,
  output logic [2:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    op_class = CLS_NONE;
    alu_ctrl = ALU_AND;
    legal    = 1'b1;
    case (funct)
      F_AND:   begin op_class = CLS_ALU; alu_ctrl = ALU_AND; end
      F_OR:    begin op_class = CLS_ALU; alu_ctrl = ALU_OR;  end
      F_ADD:   begin op_class = CLS_ALU; alu_ctrl = ALU_ADD; end
      F_SUB:   begin op_class = CLS_ALU; alu_ctrl = ALU_SUB; end
      F_SLT:   begin op_class = CLS_ALU; alu_ctrl = ALU_SLT; end
      F_SLL:   op_class = CLS_SHIFT;
      F_MFHI:  op_class = CLS_HILO;
      F_MFLO:  op_class = CLS_HILO;
      F_MULTU: op_class = CLS_MULT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control FSM timing one R-type operation per start: single-cycle ALU/shift/HI-LO
// reads, a MULT_CYCLES-iteration shift-add MULTU, and an error path for bad functs.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int CNT_W       = 5
) (
  input logic               clk,
  input logic               reset,
  alu_op_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(MULT_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [5:0]       op_reg;
  logic [2:0]       ctrl_reg;
  logic             err_reg;
  logic [CNT_W-1:0] iter_cnt;

  op_class_t  dec_class;
  logic [2:0] dec_ctrl;
  logic       dec_legal;

  funct_decode u_decode (
    .funct    (bus.funct),
    .op_class (dec_class),
    .alu_ctrl (dec_ctrl),
    .legal    (dec_legal)
  );

  // Decode results are latched with the funct so every output stays Moore.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_reg   <= '0;
      ctrl_reg <= ALU_AND;
      err_reg  <= 1'b0;
      iter_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && bus.start) begin
        op_reg   <= bus.funct;
        ctrl_reg <= dec_ctrl;
        err_reg  <= ~dec_legal;
      end
      if (state == S_MLOAD) begin
        iter_cnt <= '0;
      end else if (state == S_MULT) begin
        iter_cnt <= (iter_cnt == ITER_LAST) ? '0 : iter_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          case (dec_class)
            CLS_ALU, CLS_SHIFT, CLS_HILO: state_nxt = S_EXEC;
            CLS_MULT:                     state_nxt = S_MLOAD;
            default:                      state_nxt = S_ERR;
          endcase
        end
      end
      S_EXEC:  state_nxt = S_DONE;
      S_MLOAD: state_nxt = S_MULT;
      S_MULT:  state_nxt = (iter_cnt == ITER_LAST) ? S_MWB : S_MULT;
      S_MWB:   state_nxt = S_DONE;
      S_ERR:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.mux_sel   = IDLE_SEL;
    bus.alu_ctrl  = ALU_AND;
    bus.rf_we     = 1'b0;
    bus.mult_load = 1'b0;
    bus.mult_step = 1'b0;
    bus.hilo_we   = 1'b0;
    case (state)
      S_EXEC: begin
        bus.mux_sel  = op_reg;
        bus.alu_ctrl = ctrl_reg;
        bus.rf_we    = 1'b1;
      end
      S_MLOAD: bus.mult_load = 1'b1;
      S_MULT:  bus.mult_step = 1'b1;
      S_MWB:   bus.hilo_we   = 1'b1;
      S_DONE: begin
        bus.done = 1'b1;
        bus.err  = err_reg;
      end
      default: ;
    endcase
  end

  assign bus.iter_cnt = iter_cnt;
  assign bus.state    = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: reset, single-cycle ops, MULTU timing,
// illegal codes, busy rejection, back-to-back issue and reset abort.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   done_cnt;
  int   hilo_cnt;
  int   rfwe_cnt;
  logic [31:0] exp_q[$];

  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done)    done_cnt++;
    if (bus.hilo_we) hilo_cnt++;
    if (bus.rf_we)   rfwe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f);
    bus.funct = f;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  logic [5:0] tbl_f [7];
  logic [2:0] tbl_c [7];

  initial begin
    int d0;
    int h0;
    int r0;
    int steps;
    int hilo_cyc;
    int done_cyc;
    int done_err;

    checks   = 0;
    failures = 0;
    done_cnt = 0;
    hilo_cnt = 0;
    rfwe_cnt = 0;
    tbl_f = '{F_AND, F_OR, F_SUB, F_SLT, F_SLL, F_MFHI, F_MFLO};
    tbl_c = '{3'b000, 3'b001, 3'b110, 3'b111, 3'b000, 3'b000, 3'b000};

    bus.start = 1'b0;
    bus.funct = 6'd0;
    reset     = 1'b1;
    repeat (3) tick();

    // reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
    chk("rst_strobes", 32'({bus.rf_we, bus.mult_load, bus.mult_step, bus.hilo_we}), 32'd0);
    chk("rst_mux_sel", 32'(bus.mux_sel), 32'h3f);
    chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    chk("rst_iter_cnt", 32'(bus.iter_cnt), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    reset = 1'b0;
    tick();

    // ADD
    issue(6'b100000);
    chk("add_mux_sel", 32'(bus.mux_sel), 32'h20);
    chk("add_alu_ctrl", 32'(bus.alu_ctrl), 32'b010);
    chk("add_rf_we", 32'(bus.rf_we), 32'd1);
    chk("add_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("add_done", 32'({bus.done, bus.err, bus.rf_we}), 32'b100);
    tick();
    chk("add_idle", 32'({bus.busy, bus.done}), 32'd0);

    // remaining single-cycle functs
    for (int i = 0; i < 7; i++) begin
      issue(tbl_f[i]);
      chk($sformatf("op%0d_mux_sel", i), 32'(bus.mux_sel), 32'(tbl_f[i]));
      chk($sformatf("op%0d_alu_ctrl", i), 32'(bus.alu_ctrl), 32'(tbl_c[i]));
      tick();
      chk($sformatf("op%0d_done", i), 32'({bus.done, bus.err}), 32'b10);
      tick();
    end

    // MULTU full sequence
    d0 = done_cnt;
    r0 = rfwe_cnt;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i));
    steps    = 0;
    hilo_cyc = -1;
    done_cyc = -1;
    done_err = 0;
    issue(F_MULTU);
    chk("mul_load", 32'({bus.mult_load, bus.mult_step}), 32'b10);
    chk("mul_load_mux", 32'(bus.mux_sel), 32'h3f);
    for (int c = 2; c <= 40; c++) begin
      tick();
      if (bus.mult_step) begin
        steps++;
        if (exp_q.size() > 0) chk("mul_iter", 32'(bus.iter_cnt), exp_q.pop_front());
        else chk("mul_extra_step", 32'(steps), 32'd32);
      end
      if (bus.hilo_we) hilo_cyc = c;
      if (bus.done) begin
        done_cyc = c;
        done_err = int'(bus.err);
      end
    end
    chk("mul_steps", 32'(steps), 32'd32);
    chk("mul_exp_left", 32'(exp_q.size()), 32'd0);
    chk("mul_hilo_cyc", 32'(hilo_cyc), 32'd34);
    chk("mul_done_cyc", 32'(done_cyc), 32'd35);
    chk("mul_err", 32'(done_err), 32'd0);
    chk("mul_rf_we", 32'(rfwe_cnt - r0), 32'd0);
    chk("mul_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("mul_iter_wrap", 32'(bus.iter_cnt), 32'd0);

    // illegal code
    issue(6'b000011);
    chk("ill_strobes", 32'({bus.rf_we, bus.mult_load, bus.mult_step, bus.hilo_we}), 32'd0);
    chk("ill_mux_sel", 32'(bus.mux_sel), 32'h3f);
    tick();
    chk("ill_done_err", 32'({bus.done, bus.err}), 32'b11);
    tick();
    chk("ill_idle", 32'({bus.busy, bus.err}), 32'd0);

    // busy rejection during MULTU
    d0 = done_cnt;
    issue(F_MULTU);
    for (int c = 1; c <= 37; c++) begin
      if (c == 5 || c == 34) begin
        bus.funct = F_MFHI;
        bus.start = 1'b1;
      end
      tick();
      bus.start = 1'b0;
    end
    chk("rej_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("rej_idle", 32'({bus.busy, bus.rf_we}), 32'd0);
    issue(F_MFHI);
    chk("mfhi_mux_sel", 32'(bus.mux_sel), 32'h10);
    chk("mfhi_rf_we", 32'(bus.rf_we), 32'd1);
    tick();
    chk("mfhi_done", 32'({bus.done, bus.mux_sel}), 32'h7f);

    // SLL then SLT back-to-back
    tick();
    d0 = done_cnt;
    issue(F_SLL);
    chk("sll_exec", 32'({bus.mux_sel, bus.alu_ctrl}), 32'd0);
    chk("sll_state", 32'(bus.state), 32'(S_EXEC));
    tick();
    chk("sll_done", 32'(bus.done), 32'd1);
    tick();
    chk("sll_idle", 32'(bus.busy), 32'd0);
    issue(F_SLT);
    chk("slt_alu_ctrl", 32'(bus.alu_ctrl), 32'b111);
    chk("slt_mux_sel", 32'(bus.mux_sel), 32'h2a);
    tick();
    tick();
    chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);

    // reset mid-MULTU
    d0 = done_cnt;
    h0 = hilo_cnt;
    issue(F_MULTU);
    for (int i = 0; i < 40 && bus.iter_cnt != 5'd10; i++) tick();
    chk("abort_iter_reached", 32'(bus.iter_cnt), 32'd10);
    reset = 1'b1;
    tick();
    chk("abort_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    chk("abort_iter", 32'(bus.iter_cnt), 32'd0);
    chk("abort_mux_sel", 32'(bus.mux_sel), 32'h3f);
    repeat (40) tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_no_hilo", 32'(hilo_cnt - h0), 32'd0);
    chk("abort_idle", 32'({bus.busy, bus.state}), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
